// File: rtl/pe2ddr_wr_pkg.sv
// pe2ddr_wr_pkg: global widths, bw() helper, config bundle, FSM states.
// Shared by the write-back engine, its FIFO and the config unit.
package pe2ddr_wr_pkg;

  localparam int DATA_W     = 16;
  localparam int BATCH      = 4;
  localparam int DDR_W      = 64;
  localparam int DDR_ADDR_W = 32;
  localparam int BURST_W    = 8;

  function automatic int bw(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  localparam int PE_NUM_DEF    = 32;
  localparam int BUF_DEPTH_DEF = 256;
  localparam int BUF_AW_DEF    = bw(BUF_DEPTH_DEF);

  typedef struct packed {
    logic [PE_NUM_DEF-1:0] mask;
    logic [BUF_AW_DEF-1:0] buf_addr;
    logic [BURST_W-1:0]    burst;
    logic [BURST_W-1:0]    burst_num;
    logic [DDR_ADDR_W-1:0] st_addr;
    logic [DDR_ADDR_W-1:0] step;
  } pe2ddr_conf_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } pe2ddr_state_e;

endpackage

// File: rtl/pe2ddr_wr_if.sv
// pe2ddr_wr_if: DDR write port, burst address channel plus data channel.
// master: engine side (drives valids/payload); slave: arbiter side.
interface pe2ddr_wr_if;
  import pe2ddr_wr_pkg::*;

  logic [DDR_ADDR_W-1:0] ddr_addr;
  logic [BURST_W-1:0]    ddr_size;
  logic                  ddr_addr_valid;
  logic                  ddr_addr_ready;
  logic [DDR_W-1:0]      ddr_data;
  logic                  ddr_data_last;
  logic                  ddr_data_valid;
  logic                  ddr_data_ready;

  modport master (
    output ddr_addr, ddr_size, ddr_addr_valid,
    output ddr_data, ddr_data_last, ddr_data_valid,
    input  ddr_addr_ready, ddr_data_ready
  );

  modport slave (
    input  ddr_addr, ddr_size, ddr_addr_valid,
    input  ddr_data, ddr_data_last, ddr_data_valid,
    output ddr_addr_ready, ddr_data_ready
  );

endinterface

// File: rtl/pe2ddr_wr_fifo.sv
// pe2ddr_fifo: DEPTH x W synchronous FIFO with occupancy count.
// Ports: clk, rst (async low), push/push_data, pop/pop_data, empty, count.
module pe2ddr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (push) begin
      mem_d[wp_q] = push_data;
      wp_d        = wp_q + PW'(1);
    end
    if (pop) rp_d = rp_q + PW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign pop_data = mem_q[rp_q];
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;

endmodule

// File: rtl/pe2ddr_wr.sv
// pe2ddr_wr: drains masked PE result buffers into one DDR write port.
// Ports: clk, rst (async low), start/done, conf_* job config,
//   buf_rd_en/addr/data buffer read port, ddr (pe2ddr_wr_if.master),
//   perf_stall_cnt (live only with `define PE2DDR_PERF_CNT_EN).
module pe2ddr_wr
  import pe2ddr_wr_pkg::*;
#(
  parameter int BUF_DEPTH  = 256,
  parameter int PE_NUM     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      done,
  input  logic [PE_NUM-1:0]         conf_mask,
  input  logic [bw(BUF_DEPTH)-1:0]  conf_buf_addr,
  input  logic [BURST_W-1:0]        conf_burst,
  input  logic [BURST_W-1:0]        conf_burst_num,
  input  logic [DDR_ADDR_W-1:0]     conf_st_addr,
  input  logic [DDR_ADDR_W-1:0]     conf_step,
  output logic [PE_NUM-1:0]         buf_rd_en,
  output logic [bw(BUF_DEPTH)-1:0]  buf_rd_addr,
  input  logic [PE_NUM*DDR_W-1:0]   buf_rd_data,
  pe2ddr_wr_if.master               ddr,
  output logic [31:0]               perf_stall_cnt
);

  localparam int AW   = bw(BUF_DEPTH);
  localparam int PC_W = bw(PE_NUM + 1);
  localparam int BC_W = BURST_W + PC_W;
  localparam int DC_W = 2 * BURST_W + PC_W;
  localparam int FC_W = $clog2(FIFO_DEPTH) + 1;

  if (DDR_W != BATCH * DATA_W) begin : g_bad_ddr_w
    $error("DDR_W must equal BATCH*DATA_W");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
  begin : g_bad_fifo
    $error("FIFO_DEPTH must be a power of 2, >= 2");
  end

  pe2ddr_state_e         state_q, state_d;
  logic                  done_q, done_d;
  logic [PE_NUM-1:0]     rem_q, rem_d;
  logic [AW-1:0]         base_q, base_d;
  logic [BURST_W-1:0]    burst_q, burst_d;
  logic [BURST_W-1:0]    bnum_q, bnum_d;
  logic [DDR_ADDR_W-1:0] step_q, step_d;
  logic [AW-1:0]         ptr_q, ptr_d;
  logic [BURST_W-1:0]    beat_q, beat_d;
  logic [BURST_W-1:0]    bcnt_q, bcnt_d;
  logic [PE_NUM-1:0]     rd_en_q, rd_en_d;
  logic [AW-1:0]         rd_addr_q, rd_addr_d;
  logic                  rd_last_q, rd_last_d;
  logic                  p_vld_q, p_vld_d;
  logic [PE_NUM-1:0]     p_sel_q, p_sel_d;
  logic                  p_last_q, p_last_d;
  logic [DDR_ADDR_W-1:0] aaddr_q, aaddr_d;
  logic                  avalid_q, avalid_d;
  logic [BC_W-1:0]       aleft_q, aleft_d;
  logic [DC_W-1:0]       dleft_q, dleft_d;

  logic [PC_W-1:0]   pc;
  logic              degen;
  logic [PE_NUM-1:0] cur_oh;
  logic [FC_W-1:0]   fifo_cnt;
  logic [FC_W:0]     occ;
  logic              fifo_empty;
  logic              issue;
  logic              last_beat;
  logic              last_burst;
  logic [AW-1:0]     ptr_inc;
  logic              a_hs;
  logic              pop;
  logic [DDR_W-1:0]  rdata;
  logic [DDR_W:0]    head;

  always_comb begin
    pc = '0;
    for (int i = 0; i < PE_NUM; i++) begin
      pc = pc + PC_W'(conf_mask[i]);
    end
  end

  assign degen = (conf_mask == '0) ||
                 (conf_burst == '0) ||
                 (conf_burst_num == '0);

  // lowest remaining mask bit: skips any run of cleared bits at once
  assign cur_oh = rem_q & (~rem_q + PE_NUM'(1));

  // reads in the pipe count as FIFO slots already spoken for
  assign occ = {1'b0, fifo_cnt} +
               (FC_W+1)'(|rd_en_q) +
               (FC_W+1)'(p_vld_q);

  assign issue = (state_q == S_BUSY) && (|rem_q) &&
                 (occ < (FC_W+1)'(FIFO_DEPTH));

  assign last_beat  = (beat_q == burst_q - BURST_W'(1));
  assign last_burst = (bcnt_q == bnum_q - BURST_W'(1));
  assign ptr_inc    = (ptr_q == AW'(BUF_DEPTH - 1)) ?
                      '0 : ptr_q + AW'(1);

  assign a_hs = avalid_q && ddr.ddr_addr_ready;
  assign pop  = !fifo_empty && ddr.ddr_data_ready;

  always_comb begin
    rdata = '0;
    for (int i = 0; i < PE_NUM; i++) begin
      if (p_sel_q[i]) rdata = rdata | buf_rd_data[i*DDR_W +: DDR_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    base_d    = base_q;
    burst_d   = burst_q;
    bnum_d    = bnum_q;
    step_d    = step_q;
    ptr_d     = ptr_q;
    beat_d    = beat_q;
    bcnt_d    = bcnt_q;
    rd_en_d   = '0;
    rd_addr_d = rd_addr_q;
    rd_last_d = 1'b0;
    aaddr_d   = aaddr_q;
    avalid_d  = avalid_q;
    aleft_d   = aleft_q;
    dleft_d   = dleft_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = conf_buf_addr;
          burst_d = conf_burst;
          bnum_d  = conf_burst_num;
          step_d  = conf_step;
          if (degen) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_BUSY;
            rem_d    = conf_mask;
            ptr_d    = conf_buf_addr;
            beat_d   = '0;
            bcnt_d   = '0;
            aaddr_d  = conf_st_addr;
            avalid_d = 1'b1;
            aleft_d  = BC_W'(pc) * BC_W'(conf_burst_num);
            dleft_d  = DC_W'(pc) * DC_W'(conf_burst) *
                       DC_W'(conf_burst_num);
          end
        end
      end
      S_BUSY: begin
        if (issue) begin
          rd_en_d   = cur_oh;
          rd_addr_d = ptr_q;
          rd_last_d = last_beat;
          if (last_beat) begin
            beat_d = '0;
            if (last_burst) begin
              bcnt_d = '0;
              rem_d  = rem_q & ~cur_oh;
              ptr_d  = base_q;
            end else begin
              bcnt_d = bcnt_q + BURST_W'(1);
              ptr_d  = ptr_inc;
            end
          end else begin
            beat_d = beat_q + BURST_W'(1);
            ptr_d  = ptr_inc;
          end
        end
        if (a_hs) begin
          aaddr_d  = aaddr_q + step_q;
          aleft_d  = aleft_q - BC_W'(1);
          avalid_d = (aleft_d != '0);
        end
        if (pop) dleft_d = dleft_q - DC_W'(1);
        if (aleft_d == '0 && dleft_d == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    done_d   = (state_d == S_DONE);
    p_vld_d  = |rd_en_q;
    p_sel_d  = rd_en_q;
    p_last_d = rd_last_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      done_q    <= 1'b0;
      rem_q     <= '0;
      base_q    <= '0;
      burst_q   <= '0;
      bnum_q    <= '0;
      step_q    <= '0;
      ptr_q     <= '0;
      beat_q    <= '0;
      bcnt_q    <= '0;
      rd_en_q   <= '0;
      rd_addr_q <= '0;
      rd_last_q <= 1'b0;
      p_vld_q   <= 1'b0;
      p_sel_q   <= '0;
      p_last_q  <= 1'b0;
      aaddr_q   <= '0;
      avalid_q  <= 1'b0;
      aleft_q   <= '0;
      dleft_q   <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      rem_q     <= rem_d;
      base_q    <= base_d;
      burst_q   <= burst_d;
      bnum_q    <= bnum_d;
      step_q    <= step_d;
      ptr_q     <= ptr_d;
      beat_q    <= beat_d;
      bcnt_q    <= bcnt_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_last_q <= rd_last_d;
      p_vld_q   <= p_vld_d;
      p_sel_q   <= p_sel_d;
      p_last_q  <= p_last_d;
      aaddr_q   <= aaddr_d;
      avalid_q  <= avalid_d;
      aleft_q   <= aleft_d;
      dleft_q   <= dleft_d;
    end
  end

  pe2ddr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DDR_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (p_vld_q),
    .push_data ({p_last_q, rdata}),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign done               = done_q;
  assign buf_rd_en          = rd_en_q;
  assign buf_rd_addr        = rd_addr_q;
  assign ddr.ddr_addr       = aaddr_q;
  assign ddr.ddr_size       = burst_q;
  assign ddr.ddr_addr_valid = avalid_q;
  assign ddr.ddr_data       = head[DDR_W-1:0];
  assign ddr.ddr_data_last  = head[DDR_W];
  assign ddr.ddr_data_valid = !fifo_empty;

`ifdef PE2DDR_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && start) begin
      stall_d = '0;
    end else if (state_q == S_BUSY && !fifo_empty &&
                 !ddr.ddr_data_ready && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_q <= '0;
    else      stall_q <= stall_d;
  end

  assign perf_stall_cnt = stall_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pe2ddr_wr.sv
// tb_pe2ddr_wr: table-driven jobs checked against a bench-side model,
// plus degenerate-start and mid-job reset sequences.
module tb_pe2ddr_wr;
  import pe2ddr_wr_pkg::*;

  localparam int PE_NUM     = 32;
  localparam int BUF_DEPTH  = 256;
  localparam int FIFO_DEPTH = 4;

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic                    done;
  logic [PE_NUM-1:0]       conf_mask;
  logic [7:0]              conf_buf_addr;
  logic [7:0]              conf_burst;
  logic [7:0]              conf_burst_num;
  logic [31:0]             conf_st_addr;
  logic [31:0]             conf_step;
  logic [PE_NUM-1:0]       buf_rd_en;
  logic [7:0]              buf_rd_addr;
  logic [PE_NUM*DDR_W-1:0] buf_rd_data;
  logic [31:0]             perf;

  pe2ddr_wr_if dif();

  pe2ddr_wr #(
    .BUF_DEPTH  (BUF_DEPTH),
    .PE_NUM     (PE_NUM),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .done           (done),
    .conf_mask      (conf_mask),
    .conf_buf_addr  (conf_buf_addr),
    .conf_burst     (conf_burst),
    .conf_burst_num (conf_burst_num),
    .conf_st_addr   (conf_st_addr),
    .conf_step      (conf_step),
    .buf_rd_en      (buf_rd_en),
    .buf_rd_addr    (buf_rd_addr),
    .buf_rd_data    (buf_rd_data),
    .ddr            (dif),
    .perf_stall_cnt (perf)
  );

  typedef struct {
    logic [31:0] mask;
    logic [7:0]  ba;
    logic [7:0]  burst;
    logic [7:0]  bn;
    logic [31:0] st;
    logic [31:0] step;
    bit          bp;
    bit          poke;
    int          exp_bursts;
    int          exp_beats;
    logic [31:0] exp_last_addr;
  } job_t;

  int n_run = 0;
  int n_fail = 0;

  logic [31:0] got_addr[$];
  logic [7:0]  got_size[$];
  logic [64:0] got_beat[$];
  int done_cnt, issued, popped, max_out, stall_cyc, stab_err;
  logic pa_v, pa_r, pd_v, pd_r;
  logic [31:0] pa_addr;
  logic [64:0] pd_beat;
  bit bp_mode = 0;
  int cyc = 0;

  function automatic logic [63:0] f(input int p, input logic [7:0] a);
    logic [7:0] pp;
    pp = 8'(p);
    return {16'hBEEF, pp, a, pp ^ 8'h5A, a ^ 8'hC3, 16'h0F0F};
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // synchronous buffer: data only valid the cycle after its enable
  always @(posedge clk) begin
    for (int p = 0; p < PE_NUM; p++) begin
      buf_rd_data[p*DDR_W +: DDR_W] <= buf_rd_en[p] ?
        f(p, buf_rd_addr) : {32'hDEAD_DEAD, 24'h0, 8'(p)};
    end
  end

  initial begin
    dif.ddr_addr_ready = 1'b1;
    dif.ddr_data_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (bp_mode) begin
        dif.ddr_data_ready = (cyc >= 4 && cyc < 14) ?
          1'b0 : 1'($urandom_range(0, 1));
        dif.ddr_addr_ready = 1'($urandom_range(0, 1));
      end else begin
        dif.ddr_data_ready = 1'b1;
        dif.ddr_addr_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (dif.ddr_addr_valid && dif.ddr_addr_ready) begin
        got_addr.push_back(dif.ddr_addr);
        got_size.push_back(dif.ddr_size);
      end
      if (dif.ddr_data_valid && dif.ddr_data_ready) begin
        got_beat.push_back({dif.ddr_data_last, dif.ddr_data});
        popped++;
      end
      if (dif.ddr_data_valid && !dif.ddr_data_ready) stall_cyc++;
      issued += $countones(buf_rd_en);
      if (issued - popped > max_out) max_out = issued - popped;
      if (done) done_cnt++;
      if (pa_v && !pa_r &&
          (!dif.ddr_addr_valid || dif.ddr_addr !== pa_addr))
        stab_err++;
      if (pd_v && !pd_r &&
          (!dif.ddr_data_valid ||
           {dif.ddr_data_last, dif.ddr_data} !== pd_beat))
        stab_err++;
      pa_v    = dif.ddr_addr_valid;
      pa_r    = dif.ddr_addr_ready;
      pa_addr = dif.ddr_addr;
      pd_v    = dif.ddr_data_valid;
      pd_r    = dif.ddr_data_ready;
      pd_beat = {dif.ddr_data_last, dif.ddr_data};
    end
  end

  task automatic chk(input string name,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic clr_mon();
    got_addr.delete();
    got_size.delete();
    got_beat.delete();
    done_cnt  = 0;
    issued    = 0;
    popped    = 0;
    max_out   = 0;
    stall_cyc = 0;
    stab_err  = 0;
    pa_v      = 0;
    pd_v      = 0;
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_done"}, done, 0);
    chk({t, "_rd_en"}, buf_rd_en, 0);
    chk({t, "_rd_addr"}, buf_rd_addr, 0);
    chk({t, "_addr"}, dif.ddr_addr, 0);
    chk({t, "_size"}, dif.ddr_size, 0);
    chk({t, "_avalid"}, dif.ddr_addr_valid, 0);
    chk({t, "_data"}, dif.ddr_data, 0);
    chk({t, "_last"}, dif.ddr_data_last, 0);
    chk({t, "_dvalid"}, dif.ddr_data_valid, 0);
    chk({t, "_perf"}, perf, 0);
  endtask

  task automatic drive_start(input job_t j);
    @(posedge clk);
    #1;
    conf_mask      = j.mask;
    conf_buf_addr  = j.ba;
    conf_burst     = j.burst;
    conf_burst_num = j.bn;
    conf_st_addr   = j.st;
    conf_step      = j.step;
    start          = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic run_job(input job_t j, input int idx);
    logic [31:0] ea[$];
    logic [64:0] eb[$];
    logic [7:0]  a;
    logic        l;
    int          nb;
    string       t;
    t = $sformatf("job%0d", idx);
    nb = $countones(j.mask) * int'(j.bn);
    for (int k = 0; k < nb; k++) ea.push_back(j.st + 32'(k) * j.step);
    for (int p = 0; p < PE_NUM; p++) begin
      if (j.mask[p]) begin
        for (int b = 0; b < int'(j.burst) * int'(j.bn); b++) begin
          a = j.ba + 8'(b);
          l = ((b % int'(j.burst)) == int'(j.burst) - 1);
          eb.push_back({l, f(p, a)});
        end
      end
    end
    clr_mon();
    bp_mode = j.bp;
    cyc = 0;
    drive_start(j);
    if (j.poke) begin
      repeat (3) @(posedge clk);
      #1;
      conf_mask    = '1;
      conf_st_addr = 32'h9999_0000;
      conf_burst   = 8'd1;
      start        = 1;
      @(posedge clk);
      #1;
      start = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      if (done_cnt != 0) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1;
    bp_mode = 0;
    chk({t, "_done_cnt"}, done_cnt, 1);
    chk({t, "_bursts"}, got_addr.size(), j.exp_bursts);
    chk({t, "_beats"}, got_beat.size(), j.exp_beats);
    chk({t, "_last_addr"},
        got_addr.size() > 0 ? got_addr[$] : 'x, j.exp_last_addr);
    for (int k = 0; k < ea.size(); k++) begin
      chk($sformatf("%s_addr%0d", t, k),
          k < got_addr.size() ? got_addr[k] : 'x, ea[k]);
      chk($sformatf("%s_size%0d", t, k),
          k < got_size.size() ? got_size[k] : 'x, j.burst);
    end
    for (int k = 0; k < eb.size(); k++) begin
      chk($sformatf("%s_beat%0d", t, k),
          k < got_beat.size() ? got_beat[k] : 'x, eb[k]);
    end
    chk({t, "_outstanding_ok"}, max_out <= FIFO_DEPTH, 1);
    chk({t, "_stable"}, stab_err, 0);
`ifdef PE2DDR_PERF_CNT_EN
    chk({t, "_perf"}, perf, stall_cyc);
`else
    chk({t, "_perf"}, perf, 0);
`endif
  endtask

  job_t jobs[6];
  job_t dg;

  initial begin
    jobs[0] = '{32'h0000_0001, 8'd0, 8'd4, 8'd2, 32'h1000, 32'h100,
                1'b0, 1'b0, 2, 8, 32'h0000_1100};
    jobs[1] = '{32'h8000_0005, 8'h10, 8'd2, 8'd1, 32'h2000, 32'h40,
                1'b0, 1'b0, 3, 6, 32'h0000_2080};
    jobs[2] = '{32'h0001_0003, 8'd7, 8'd4, 8'd2, 32'h3000, 32'h20,
                1'b1, 1'b0, 6, 24, 32'h0000_30A0};
    jobs[3] = '{32'h0000_0002, 8'd254, 8'd4, 8'd2, 32'hFFFF_FFBF,
                32'h80, 1'b0, 1'b0, 2, 8, 32'h0000_003F};
    jobs[4] = '{32'h0000_0001, 8'd3, 8'd4, 8'd2, 32'h5000, 32'h100,
                1'b0, 1'b1, 2, 8, 32'h0000_5100};
    jobs[5] = '{32'h0000_0003, 8'd9, 8'd1, 8'd3, 32'h10, 32'h8,
                1'b0, 1'b0, 6, 6, 32'h0000_0038};

    rst = 0;
    start = 0;
    conf_mask = '0;
    conf_buf_addr = '0;
    conf_burst = '0;
    conf_burst_num = '0;
    conf_st_addr = '0;
    conf_step = '0;
    clr_mon();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1;

    for (int i = 0; i < 6; i++) run_job(jobs[i], i);

    dg = jobs[0];
    dg.burst = 8'd0;
    clr_mon();
    drive_start(dg);
    @(negedge clk);
    chk("degen_done_next", done, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("degen_done_cnt", done_cnt, 1);
    chk("degen_no_addr", got_addr.size(), 0);
    chk("degen_no_beat", got_beat.size(), 0);
    chk("degen_no_read", issued, 0);

    clr_mon();
    drive_start(jobs[0]);
    for (int c = 0; c < 500; c++) begin
      if (got_beat.size() >= 3) break;
      @(posedge clk);
    end
    chk("midrst_reached_beat3", got_beat.size() >= 3, 1);
    @(posedge clk);
    #3;
    rst = 0;
    #1;
    chk_zero("midrst");
    @(posedge clk);
    #3;
    rst = 1;
    run_job(jobs[0], 10);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
